jtpinpon_dwnld: RTL



---
 rtl/jtpinpon_dwnld_if.sv | 22 ++
 rtl/jtpinpon_dwnld.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/jtpinpon_dwnld_if.sv
// Loader byte stream and SDRAM write-request bundle of the Pinpon ROM download stage.
// master = the download stage, slave = the loader/SDRAM side driving it.
interface jtpinpon_dwnld_if;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;

    modport master (
        input  ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we
    );

    modport slave (
        output ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we
    );
endinterface

// File: rtl/jtpinpon_dwnld.sv
// Pinpon ROM download stage: char/obj swizzle, PROM routing, 2-deep SDRAM write queue.
// Optional macro JTPINPON_DWNLD_SUM_EN builds the download checksum; otherwise sum reads 0.
module jtpinpon_dwnld #(
    parameter logic [21:0] SCR_START  = 22'h08000,
    parameter logic [21:0] OBJ_START  = 22'h0A000,
    parameter logic [24:0] PROM_START = 25'h0C000,
    parameter bit          SWAB       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             downloading,
    jtpinpon_dwnld_if.master bus,
    output logic             prom_we,
    output logic [10:0]      prom_addr,
    output logic [7:0]       prom_data,
    output logic             dwnld_busy,
    output logic             overflow,
    output logic [15:0]      sum
);
    localparam logic [21:0] PROM_LO  = PROM_START[21:0];
    localparam logic [10:0] PROM_OFS = PROM_START[10:0];

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } entry_t;

    state_t      state;
    entry_t      fifo [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        dl_q;

    logic [21:0] a;
    logic [22:0] p;
    logic        is_prom, is_char, is_obj, lane;
    entry_t      in_entry, head;
    logic        wr_ok, prom_hit, push_req, pop, push, drop, avail, rise;

    always_comb begin
        a       = bus.ioctl_addr[21:0];
        is_prom = bus.ioctl_addr >= PROM_START;
        is_char = !is_prom && (a >= SCR_START) && (a < OBJ_START);
        is_obj  = !is_prom && (a >= OBJ_START) && (a < PROM_LO);
        p       = bus.ioctl_addr[22:0];
        if (is_char) begin
            p[0]   = a[3];
            p[3:1] = a[2:0] ^ 3'd1;
        end else if (is_obj) begin
            p[0]   = ~a[3];
            p[1]   = ~a[4];
            p[5:2] = {a[5], a[2:0]};
        end
        lane          = p[0] ^ SWAB;
        in_entry.addr = p[22:1];
        in_entry.data = bus.ioctl_dout;
        in_entry.mask = lane ? 2'b01 : 2'b10;
    end

    // A pop in the same cycle frees the slot, so a push into a full queue is only dropped without one.
    assign wr_ok    = downloading & bus.ioctl_wr;
    assign prom_hit = wr_ok & is_prom;
    assign push_req = wr_ok & ~is_prom;
    assign pop      = (state == REQ) & bus.sdram_ack;
    assign push     = push_req & ((count != 2'd2) | pop);
    assign drop     = push_req & (count == 2'd2) & ~pop;
    assign avail    = (count != 2'd0) | push;
    assign head     = (count != 2'd0) ? fifo[rd_ptr] : in_entry;
    assign rise     = downloading & ~dl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= in_entry;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // An empty queue forwards the incoming byte straight to the SDRAM request for one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.prog_we   <= 1'b0;
            bus.prog_addr <= 22'd0;
            bus.prog_data <= 8'd0;
            bus.prog_mask <= 2'b11;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (avail) begin
                        state         <= REQ;
                        bus.prog_we   <= 1'b1;
                        bus.prog_addr <= head.addr;
                        bus.prog_data <= head.data;
                        bus.prog_mask <= head.mask;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.sdram_ack) begin
                        state       <= GAP;
                        bus.prog_we <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.prog_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            overflow   <= 1'b0;
            prom_we    <= 1'b0;
            prom_addr  <= 11'd0;
            prom_data  <= 8'd0;
            dwnld_busy <= 1'b0;
        end else begin
            dl_q    <= downloading;
            prom_we <= prom_hit;
            if (prom_hit) begin
                prom_addr <= bus.ioctl_addr[10:0] - PROM_OFS;
                prom_data <= bus.ioctl_dout;
            end
            if (rise) begin
                overflow <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            dwnld_busy <= downloading | (count != 2'd0) | (state != IDLE);
        end
    end

`ifdef JTPINPON_DWNLD_SUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 16'd0;
        end else begin
            sum <= (rise ? 16'd0 : sum) + ((push | prom_hit) ? {8'd0, bus.ioctl_dout} : 16'd0);
        end
    end
`else
    assign sum = 16'd0;
`endif
endmodule
